// File: rtl/bpi_flash_pkg.sv
// bpi_flash_pkg: shared constants for the BPI flash sequencer.
// Holds the command op encodings, sequencer states, CFI command words and status register bit indices.
package bpi_flash_pkg;
    localparam int AXI_DW = 32;

    typedef enum logic [1:0] {
        OP_PROG  = 2'd0,
        OP_ERASE = 2'd1,
        OP_CLR   = 2'd2,
        OP_RSV   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        BUS_WR,
        GAP,
        BUS_RD,
        CHECK,
        RDARR,
        DONE
    } state_e;

    localparam logic [15:0] CFI_PROG_SETUP    = 16'h0040;
    localparam logic [15:0] CFI_ERASE_SETUP   = 16'h0020;
    localparam logic [15:0] CFI_ERASE_CONFIRM = 16'h00D0;
    localparam logic [15:0] CFI_CLR_STATUS    = 16'h0050;
    localparam logic [15:0] CFI_READ_STATUS   = 16'h0070;
    localparam logic [15:0] CFI_READ_ARRAY    = 16'h00FF;

    localparam int ST_READY     = 7;
    localparam int ST_ERASE_ERR = 5;
    localparam int ST_PROG_ERR  = 4;
    localparam int ST_VPP_ERR   = 3;
    localparam int ST_LOCK_ERR  = 1;
endpackage

// File: rtl/bpi_flash_seq_if.sv
// bpi_flash_seq_if: AXI4-Lite bus (32-bit data) between the sequencer and the BPI flash slave.
// Parameter AW: byte address width. Modports: master (sequencer side), slave (flash side).
interface bpi_flash_seq_if
    import bpi_flash_pkg::*;
#(
    parameter int AW = 27
);
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [AXI_DW-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [AXI_DW-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/bpi_flash_seq_bus.sv
// bpi_flash_seq_bus: one 16-bit flash write or read as a single AXI4-Lite transfer.
// Ports: clk, rst; start/wr/addr/data launch a transfer; done pulses one cycle after the
// B or R handshake with resp and the addressed 16-bit lane in rdata; m_axi is the AXI master.
module bpi_flash_seq_bus
    import bpi_flash_pkg::*;
#(
    parameter int AW = 27
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   data,
    output logic          done,
    output logic [1:0]    resp,
    output logic [15:0]   rdata,
    bpi_flash_seq_if.master m_axi
);
    logic hi;
    logic unused_addr;

    assign unused_addr = addr[0];
    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
            m_axi.awaddr  <= '0;
            m_axi.araddr  <= '0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            hi    <= 1'b0;
            done  <= 1'b0;
            resp  <= 2'b00;
            rdata <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                hi <= addr[1];
                if (wr) begin
                    m_axi.awvalid <= 1'b1;
                    m_axi.wvalid  <= 1'b1;
                    m_axi.bready  <= 1'b1;
                    m_axi.awaddr  <= {addr[AW-1:2], 2'b00};
                    m_axi.wdata   <= {data, data};
                    m_axi.wstrb   <= addr[1] ? 4'b1100 : 4'b0011;
                end else begin
                    m_axi.arvalid <= 1'b1;
                    m_axi.rready  <= 1'b1;
                    m_axi.araddr  <= {addr[AW-1:2], 2'b00};
                end
            end
            // AW and W are independent channels; each valid drops on its own handshake.
            if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
            if (m_axi.wvalid && m_axi.wready) m_axi.wvalid <= 1'b0;
            if (m_axi.arvalid && m_axi.arready) m_axi.arvalid <= 1'b0;
            if (m_axi.bvalid && m_axi.bready) begin
                m_axi.bready <= 1'b0;
                done <= 1'b1;
                resp <= m_axi.bresp;
            end
            if (m_axi.rvalid && m_axi.rready) begin
                m_axi.rready <= 1'b0;
                done  <= 1'b1;
                resp  <= m_axi.rresp;
                rdata <= hi ? m_axi.rdata[31:16] : m_axi.rdata[15:0];
            end
        end
    end
endmodule

// File: rtl/bpi_flash_seq.sv
// bpi_flash_seq: CFI program / block-erase / clear-status sequencer for a BPI flash behind AXI4-Lite.
// Ports: clk, rst; cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data command; done_valid/done_status/
// done_error completion; m_axi AXI4-Lite master. Define BPI_FLASH_SEQ_TIMEOUT_EN for a poll timeout.
module bpi_flash_seq
    import bpi_flash_pkg::*;
#(
    parameter int C_MEM_SIZE       = 134217728,
    parameter int C_POLL_GAP       = 16,
    parameter int C_TIMEOUT_CYCLES = 2**26,
    localparam int AW = $clog2(C_MEM_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [15:0]   cmd_data,
    output logic          done_valid,
    output logic [7:0]    done_status,
    output logic          done_error,
    bpi_flash_seq_if.master m_axi
);
    state_e        state, state_nx;
    op_e           op;
    logic [AW-1:0] addr;
    logic [15:0]   data, bus_wdata, bus_rdata, gap_cnt;
    logic [7:0]    status;
    logic [1:0]    resp;
    logic          idx, ph, issued, err, start, wr, bd, tmo;
    logic          unused_rd;

    assign unused_rd = ^bus_rdata[15:8];

    bpi_flash_seq_bus #(.AW(AW)) u_bus (
        .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .data(bus_wdata),
        .done(bd), .resp(resp), .rdata(bus_rdata), .m_axi(m_axi)
    );

`ifdef BPI_FLASH_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    // Counts every cycle spent polling; the abort is only taken in GAP/CHECK so no transfer is cut off.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) tmo_cnt <= '0;
        else if ((state == GAP || state == BUS_RD || state == CHECK) && !tmo) tmo_cnt <= tmo_cnt + 1'b1;
    end
    assign tmo = tmo_cnt >= TW'(C_TIMEOUT_CYCLES - 1);
`else
    logic unused_tmo;
    assign unused_tmo = C_TIMEOUT_CYCLES[0];
    assign tmo = 1'b0;
`endif

    assign start       = (state == BUS_WR || state == BUS_RD || state == RDARR) && !issued;
    assign cmd_ready   = state == IDLE;
    assign done_valid  = state == DONE;
    assign done_status = status;
    assign done_error  = err;

    always_comb begin
        state_nx  = state;
        wr        = 1'b1;
        bus_wdata = CFI_READ_ARRAY;
        case (state)
            IDLE:   if (cmd_valid) state_nx = (cmd_op == OP_RSV) ? DONE : BUS_WR;
            BUS_WR: begin
                bus_wdata = idx ? ((op == OP_PROG) ? data : CFI_ERASE_CONFIRM)
                                : (op == OP_PROG) ? CFI_PROG_SETUP : (op == OP_ERASE) ? CFI_ERASE_SETUP : CFI_CLR_STATUS;
                if (bd) state_nx = (resp != 2'b00 || op == OP_CLR) ? RDARR : idx ? GAP : BUS_WR;
            end
            GAP:    state_nx = tmo ? RDARR : (gap_cnt == 16'(C_POLL_GAP - 1)) ? BUS_RD : GAP;
            // A poll is two transfers: the read-status command (ph=0), then the status read (ph=1).
            BUS_RD: begin
                wr        = !ph;
                bus_wdata = CFI_READ_STATUS;
                if (bd) state_nx = (resp != 2'b00) ? RDARR : ph ? CHECK : BUS_RD;
            end
            CHECK:  state_nx = (status[ST_READY] || tmo) ? RDARR : GAP;
            RDARR:  if (bd) state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op      <= OP_PROG;
            addr    <= '0;
            data    <= '0;
            status  <= '0;
            err     <= 1'b0;
            idx     <= 1'b0;
            ph      <= 1'b0;
            issued  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : '0;
            if (state == IDLE && cmd_valid) begin
                op     <= op_e'(cmd_op);
                addr   <= cmd_addr;
                data   <= cmd_data;
                status <= '0;
                err    <= cmd_op == OP_RSV;
                idx    <= 1'b0;
                ph     <= 1'b0;
            end
            if (start) issued <= 1'b1;
            if (bd) begin
                issued <= 1'b0;
                if (resp != 2'b00) err <= 1'b1;
            end
            if (state == BUS_WR && bd) idx <= 1'b1;
            if (state == BUS_RD && bd) begin
                ph <= !ph;
                if (ph && resp == 2'b00) status <= bus_rdata[7:0];
            end
            if (state == CHECK && status[ST_READY])
                err <= err | (|status[ST_ERASE_ERR:ST_VPP_ERR]) | status[ST_LOCK_ERR];
            if (state_nx == RDARR && (state == GAP || (state == CHECK && !status[ST_READY]))) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bpi_flash_seq.sv
// tb_bpi_flash_seq: directed bench for bpi_flash_seq with a logging AXI4-Lite flash slave model.
// Exercises reset, program, erase, clear status, reserved op, bus errors, AW stall, mid-poll reset
// and, when BPI_FLASH_SEQ_TIMEOUT_EN is defined, the poll timeout.
module tb_bpi_flash_seq;
    import bpi_flash_pkg::*;
    localparam int AW  = 27;
    localparam int GAP = 8;
`ifdef BPI_FLASH_SEQ_TIMEOUT_EN
    localparam int TMO = 200;
`else
    localparam int TMO = 2**26;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [15:0]   cmd_data = '0;
    logic          done_valid, done_error;
    logic [7:0]    done_status;
    int checks = 0, errors = 0;

    bpi_flash_seq_if #(.AW(AW)) m_axi ();

    bpi_flash_seq #(.C_POLL_GAP(GAP), .C_TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done_valid(done_valid), .done_status(done_status),
        .done_error(done_error), .m_axi(m_axi)
    );

    always #5 clk = ~clk;

    // Slave model configuration (written only by the stimulus process).
    int            aw_delay = 0, berr_idx = -1, st_len = 1, rd_base = 0, wb = 0;
    logic          hi_lane = 1'b0;
    logic [7:0]    st_list [8];
    // Slave model state and write log (written only by the slave process).
    int            nwr = 0, nrd = 0, cyc = 0, aw_run = 0, w_run = 0, aw_len = 0, w_len = 0, ndone = 0;
    logic          aw_got = 1'b0, w_got = 1'b0;
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_data;
    logic [3:0]    cap_strb;
    logic [AW-1:0] wl_addr [256];
    logic [31:0]   wl_data [256];
    logic [3:0]    wl_strb [256];
    int            wl_cyc [256], wl_awlen [256], wl_wlen [256];
    logic [15:0]   ew [$];
    logic [7:0]    res_st;
    logic          res_err;
    int            res_cyc;

    assign m_axi.awready = m_axi.awvalid && !aw_got && aw_run >= aw_delay;
    assign m_axi.wready  = m_axi.wvalid && !w_got;
    assign m_axi.arready = m_axi.arvalid;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done_valid) ndone <= ndone + 1;
        if (rst) begin
            m_axi.bvalid <= 1'b0;
            m_axi.bresp  <= 2'b00;
            m_axi.rvalid <= 1'b0;
            m_axi.rresp  <= 2'b00;
            m_axi.rdata  <= '0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_run <= 0;
            w_run  <= 0;
        end else begin
            if (m_axi.awvalid && m_axi.awready) begin
                aw_got <= 1'b1; cap_addr <= m_axi.awaddr; aw_len <= aw_run + 1; aw_run <= 0;
            end else if (m_axi.awvalid) aw_run <= aw_run + 1;
            if (m_axi.wvalid && m_axi.wready) begin
                w_got <= 1'b1; cap_data <= m_axi.wdata; cap_strb <= m_axi.wstrb; w_len <= w_run + 1; w_run <= 0;
            end else if (m_axi.wvalid) w_run <= w_run + 1;
            if (aw_got && w_got && !m_axi.bvalid) begin
                m_axi.bvalid      <= 1'b1;
                m_axi.bresp       <= (nwr == berr_idx) ? 2'b10 : 2'b00;
                wl_addr[nwr & 255]  <= cap_addr;
                wl_data[nwr & 255]  <= cap_data;
                wl_strb[nwr & 255]  <= cap_strb;
                wl_cyc[nwr & 255]   <= cyc;
                wl_awlen[nwr & 255] <= aw_len;
                wl_wlen[nwr & 255]  <= w_len;
                nwr    <= nwr + 1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (m_axi.bvalid && m_axi.bready) m_axi.bvalid <= 1'b0;
            // The unselected lane carries 0x00FF so a wrong lane pick reads as "ready with errors".
            if (m_axi.arvalid && m_axi.arready) begin
                m_axi.rvalid <= 1'b1;
                m_axi.rdata  <= hi_lane ? {8'h00, st_list[(nrd - rd_base) < st_len ? nrd - rd_base : st_len - 1], 16'h00FF}
                                        : {16'h00FF, 8'h00, st_list[(nrd - rd_base) < st_len ? nrd - rd_base : st_len - 1]};
                nrd <= nrd + 1;
            end
            if (m_axi.rvalid && m_axi.rready) m_axi.rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [AW-1:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        check({tag, "_rdy"}, cmd_ready, 1);
        wb = nwr;
        rd_base = nrd;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!done_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        res_cyc = n;
        check({tag, "_done"}, done_valid, 1);
        res_st  = done_status;
        res_err = done_error;
        @(negedge clk);
        check({tag, "_pulse"}, done_valid, 0);
    endtask

    task automatic chk_wr(input string tag, input logic [3:0] strb, input logic [AW-1:0] a);
        check({tag, "_nwr"}, 64'(nwr - wb), 64'(ew.size()));
        for (int i = 0; i < ew.size(); i++)
            check($sformatf("%s_w%0d", tag, i), {wl_addr[(wb + i) & 255], wl_strb[(wb + i) & 255], wl_data[(wb + i) & 255]},
                  {a & ~27'd3, strb, ew[i], ew[i]});
    endtask

    initial begin
        int nd, n0, rb;
        st_list[0] = 8'h80;
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready}, 0);
        check("rst_done", {done_valid, done_error, done_status}, 0);
        rst = 1'b0;

        run("prog", OP_PROG, 27'h100, 16'hA5A5);
        ew = '{16'h0040, 16'hA5A5, 16'h0070, 16'h00FF};
        chk_wr("prog", 4'b0011, 27'h100);
        check("prog_rd", 64'(nrd - rd_base), 1);
        check("prog_res", {res_err, res_st}, {1'b0, 8'h80});

        hi_lane = 1'b1;
        st_list[0] = 8'h00; st_list[1] = 8'h00; st_list[2] = 8'hA0; st_len = 3;
        run("erase", OP_ERASE, 27'h20002, 16'h0000);
        ew = '{16'h0020, 16'h00D0, 16'h0070, 16'h0070, 16'h0070, 16'h00FF};
        chk_wr("erase", 4'b1100, 27'h20002);
        check("erase_rd", 64'(nrd - rd_base), 3);
        for (int i = 2; i < 4; i++)
            check($sformatf("erase_gap%0d", i), (wl_cyc[(wb + i + 1) & 255] - wl_cyc[(wb + i) & 255]) >= GAP, 1);
        check("erase_res", {res_err, res_st}, {1'b1, 8'hA0});

        hi_lane = 1'b0;
        st_list[0] = 8'h80; st_len = 1;
        berr_idx = nwr + 1;
        run("berr", OP_PROG, 27'h8, 16'h1234);
        ew = '{16'h0040, 16'h1234, 16'h00FF};
        chk_wr("berr", 4'b0011, 27'h8);
        check("berr_rd", 64'(nrd - rd_base), 0);
        check("berr_res", {res_err, res_st}, {1'b1, 8'h00});
        berr_idx = -1;

        aw_delay = 5;
        run("awdly", OP_PROG, 27'h100, 16'h5A5A);
        ew = '{16'h0040, 16'h5A5A, 16'h0070, 16'h00FF};
        chk_wr("awdly", 4'b0011, 27'h100);
        check("awdly_awlen", 64'(wl_awlen[wb & 255]), 6);
        check("awdly_wlen", 64'(wl_wlen[wb & 255]), 1);
        check("awdly_res", {res_err, res_st}, {1'b0, 8'h80});
        aw_delay = 0;

        run("clr", OP_CLR, 27'h4, 16'h0000);
        ew = '{16'h0050, 16'h00FF};
        chk_wr("clr", 4'b0011, 27'h4);
        check("clr_rd", 64'(nrd - rd_base), 0);
        check("clr_res", {res_err, res_st}, {1'b0, 8'h00});

        run("rsv", OP_RSV, 27'h2, 16'h0000);
        ew = {};
        chk_wr("rsv", 4'b0000, 27'h2);
        check("rsv_res", {res_err, res_st}, {1'b1, 8'h00});
        repeat (3) @(negedge clk);
        check("hold", {done_valid, done_error, done_status}, {1'b0, 1'b1, 8'h00});

        st_list[0] = 8'h00;
        rb = nrd;
        rd_base = nrd;
        cmd_valid = 1'b1; cmd_op = OP_ERASE; cmd_addr = 27'h40; cmd_data = 16'h0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("rstp_polled", nrd > rb, 1);
        nd = ndone;
        rst = 1'b1;
        @(negedge clk);
        check("rstp_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready}, 0);
        check("rstp_state", {cmd_ready, done_valid, done_error, done_status}, {1'b1, 1'b0, 1'b0, 8'h00});
        n0 = nwr;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstp_nodone", 64'(ndone), 64'(nd));
        check("rstp_nordarr", 64'(nwr), 64'(n0));

        run("post", OP_CLR, 27'h0, 16'h0000);
        ew = '{16'h0050, 16'h00FF};
        chk_wr("post", 4'b0011, 27'h0);

`ifdef BPI_FLASH_SEQ_TIMEOUT_EN
        st_list[0] = 8'h00; st_len = 1;
        run("tmo", OP_PROG, 27'h40, 16'h1111);
        check("tmo_res", {res_err, res_st}, {1'b1, 8'h00});
        check("tmo_cyc", res_cyc <= TMO + 100, 1);
        check("tmo_polled", nrd > rd_base, 1);
        check("tmo_rdarr", wl_data[(nwr - 1) & 255], 32'h00FF00FF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bpi_flash_seq.md
BPI_FLASH_SEQ -- requirements
Module: bpi_flash_seq

Interface
REQ-001 SHALL have parameter C_MEM_SIZE, default 134217728, flash size in bytes; address width AW = $clog2(C_MEM_SIZE).
REQ-002 SHALL have parameter C_POLL_GAP, default 16, idle cycles between status polls (1..65535).
REQ-003 SHALL have parameter C_TIMEOUT_CYCLES, default 2**26, poll budget per operation.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_op  in  2  0=program word, 1=erase block, 2=clear status, 3=reserved.
REQ-008 cmd_addr  in  AW  byte address; bit 0 ignored.
REQ-009 cmd_data  in  16  program data.
REQ-010 done_valid  out  1  one-cycle completion pulse.
REQ-011 done_status  out  8  last flash status register, 0 if none read.
REQ-012 done_error  out  1  operation failed.
REQ-013 m_axi_aw*/w*/b*/ar*/r*  AXI4-Lite master, 32-bit data, AW-bit address, awprot/arprot = 0; drives the BPI flash AXI slave.

Function
REQ-014 SHALL accept a command only in IDLE; cmd_ready = 1 exactly in IDLE.
REQ-015 SHALL run FSM IDLE -> BUS_WR -> (BUS_WR | GAP -> BUS_RD -> CHECK) -> RDARR -> DONE -> IDLE.
REQ-016 Program sequence SHALL be: 0x0040 @addr, cmd_data @addr, poll.
REQ-017 Erase sequence SHALL be: 0x0020 @addr, 0x00D0 @addr, poll.
REQ-018 Clear status SHALL be: 0x0050 @addr; no polling; done_status = 0.
REQ-019 Polling SHALL be: wait C_POLL_GAP cycles, write 0x0070 @addr, read @addr, status = 16-bit lane byte 0.
REQ-020 Each 16-bit bus write SHALL replicate data in both halves of wdata, wstrb = 4'b0011 if addr[1]=0 else 4'b1100; awaddr = addr with bits [1:0] cleared; read lane selected by addr[1].
REQ-021 awvalid and wvalid SHALL assert together and drop independently on their handshake; bready = 1 while waiting; next write not issued before bvalid.
REQ-022 arvalid SHALL hold until arready; rready = 1 while waiting.
REQ-023 CHECK: status[7]=0 -> GAP again; status[7]=1 -> RDARR; done_error = |status[5:3] | status[1].
REQ-024 Any bresp or rresp != 2'b00 SHALL set done_error and skip directly to RDARR.
REQ-025 RDARR SHALL always write 0x00FF @addr before DONE.
REQ-026 cmd_op = 3 SHALL complete in one DONE pulse with done_error = 1, no bus traffic.
REQ-027 done_valid SHALL be high one cycle in DONE; done_status/done_error SHALL hold until the next command is accepted.
REQ-028 Latency from accept to done_valid SHALL be fixed only by bus handshakes, gaps and polls; no extra idle cycles beyond one per state transition.

Reset
REQ-029 On rst: state IDLE, cmd_ready 1, all AXI valids 0, bready/rready 0, done_valid 0, done_status 0, done_error 0, counters 0.
REQ-030 rst mid-transaction SHALL abandon the sequence immediately; no RDARR is issued.

Configuration
REQ-031 With BPI_FLASH_SEQ_TIMEOUT_EN defined: a poll-cycle counter SHALL abort after C_TIMEOUT_CYCLES cycles in GAP/BUS_RD/CHECK, set done_error, done_status = last read value, go to RDARR.
REQ-032 Without BPI_FLASH_SEQ_TIMEOUT_EN: no timeout counter exists; polling continues indefinitely.

Structure
REQ-033 Shared package bpi_flash_pkg SHALL hold op encodings, CFI command constants (0x40, 0x20, 0xD0, 0x50, 0x70, 0xFF) and status bit indices.
REQ-034 Sub-module bpi_flash_seq_bus SHALL implement a single 16-bit write/read AXI4-Lite transfer (REQ-020..022) with start/done/resp interface.

Verification
REQ-035 Program 0xA5A5 @0x100, slave status 0x80 on first poll -> writes 0x40, 0xA5A5, 0x70, read, 0xFF, wstrb 0011; done_error 0, done_status 0x80.
REQ-036 Erase @0x20002, status 0x00 twice then 0xA0 -> writes 0x20, 0xD0, three polls spaced >= C_POLL_GAP, wstrb 1100, done_error 1, done_status 0xA0.
REQ-037 Program with bresp = 2'b10 on data write -> no polling, 0xFF write issued, done_error 1.
REQ-038 Slave delays awready 5 cycles, wready 0 cycles -> wvalid drops after 1 cycle, awvalid after 6, single write observed.
REQ-039 TIMEOUT_EN, C_TIMEOUT_CYCLES = 200, status stuck 0x00 -> done_error 1 within 200 + bus cycles, 0xFF written.
REQ-040 rst asserted during polling -> next cycle all valids 0, cmd_ready 1, no done_valid pulse.
